single_add_sub_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-precision three-operand add/sub unit (d = a + b - c, fixed LATENCY cycles, valid in / valid out) between N requesters.
- Accepts one operand triple per cycle, registers it onto the unit's inputs, and tracks the requester ID through a tag pipeline matched to the unit latency.
- Routes each result back to its owner with a registered response.
- Sits between compute clients (filters, accumulators) and the shared FP unit.

---
 rtl/single_add_sub_arbiter.sv | 132 +++++++++++++
 tb/tb_single_add_sub_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/single_add_sub_arbiter.sv
// Round-robin sharing of one three-operand FP add/sub unit (d = a + b - c) among N requesters.
// Issue 1 cycle after grant, response LATENCY+2 cycles after grant; no response backpressure, so a grant is issued every cycle a request exists.
module single_add_sub_arbiter #(
  parameter int N       = 4,
  parameter int LATENCY = 1,
  parameter int IDW     = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  input  logic [32*N-1:0]   req_c,
  output logic              op_valid,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  output logic [31:0]       op_c,
  input  logic              res_valid,
  input  logic [31:0]       res_d,
  output logic [N-1:0]      rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_d,
  output logic              busy
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] cand;
  logic           gnt_vld;
  logic [31:0]    sel_a, sel_b, sel_c;
  logic [IDW-1:0] op_id;
  tag_t           tag_pipe [LATENCY];
  tag_t           head;
  logic           tag_any;

  // First requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    req_ready = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % N);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
    if (reset) gnt_vld = 1'b0;
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
        sel_c = req_c[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      op_valid <= 1'b0;
      op_id    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
    end else begin
      op_valid <= gnt_vld;
      op_id    <= gnt_id;
      if (gnt_vld) begin
        rr_ptr <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_c   <= sel_c;
      end
    end
  end

  // Owner tags ride alongside the unit so the head lines up with res_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= {op_valid, op_id};
      for (int s = 1; s < LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign head = tag_pipe[LATENCY-1];

  always_comb begin
    tag_any = 1'b0;
    for (int s = 0; s < LATENCY; s++) tag_any = tag_any | tag_pipe[s].vld;
  end

  // A result without a matching tag (or vice versa) is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_d     <= '0;
    end else begin
      rsp_valid <= '0;
      if (res_valid && head.vld) begin
        rsp_valid <= N'(1) << head.id;
        rsp_id    <= head.id;
        rsp_d     <= res_d;
      end
    end
  end

  assign busy = op_valid | tag_any | (|rsp_valid);

  property p_res_matches_tag;
    @(posedge clk) disable iff (reset) res_valid == head.vld;
  endproperty
  a_res_matches_tag: assert property (p_res_matches_tag);

endmodule

// File: tb/tb_single_add_sub_arbiter.sv
// Directed bench: LATENCY=1 and LATENCY=3 arbiters share the same requesters, each with its own unit model.
module tb_single_add_sub_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  // Per-requester operand triples and the unit's hand-computed d = a + b - c.
  localparam logic [31:0] A_TAB [4] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h40000000};
  localparam logic [31:0] B_TAB [4] = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h40800000};
  localparam logic [31:0] C_TAB [4] = '{32'h3F000000, 32'h40A00000, 32'h40000000, 32'h3F800000};
  localparam logic [31:0] D_TAB [4] = '{32'h40200000, 32'hC0000000, 32'h00000000, 32'h40A00000};

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_valid, req_ready, req_ready3;
  logic [32*N-1:0]  req_a, req_b, req_c;
  logic             op_valid, op_valid3;
  logic [31:0]      op_a, op_b, op_c, op_a3, op_b3, op_c3;
  logic             res_valid, res_valid3;
  logic [31:0]      res_d, res_d3;
  logic [N-1:0]     rsp_valid, rsp_valid3;
  logic [IDW-1:0]   rsp_id, rsp_id3;
  logic [31:0]      rsp_d, rsp_d3;
  logic             busy, busy3;

  int passes = 0;
  int total  = 0;
  int hist [1:5];
  int last_id, last_id3;
  logic [31:0] last_a, last_b, last_c, last_d, last_d3;

  single_add_sub_arbiter #(.N(N), .LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .res_valid(res_valid), .res_d(res_d),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_d(rsp_d), .busy(busy)
  );

  single_add_sub_arbiter #(.N(N), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .op_valid(op_valid3), .op_a(op_a3), .op_b(op_b3), .op_c(op_c3),
    .res_valid(res_valid3), .res_d(res_d3),
    .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_d(rsp_d3), .busy(busy3)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fp_unit(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    for (int i = 0; i < 4; i++)
      if (a == A_TAB[i] && b == B_TAB[i] && c == C_TAB[i]) return D_TAB[i];
    return 32'hDEADBEEF;
  endfunction

  // Behavioural unit models, cleared by the shared reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_d     <= '0;
    end else begin
      res_valid <= op_valid;
      res_d     <= fp_unit(op_a, op_b, op_c);
    end
  end

  logic [2:0]  u3_vld;
  logic [31:0] u3_d [3];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      u3_vld <= '0;
      for (int s = 0; s < 3; s++) u3_d[s] <= '0;
    end else begin
      u3_vld  <= {u3_vld[1:0], op_valid3};
      u3_d[0] <= fp_unit(op_a3, op_b3, op_c3);
      u3_d[1] <= u3_d[0];
      u3_d[2] <= u3_d[1];
    end
  end
  assign res_valid3 = u3_vld[2];
  assign res_d3     = u3_d[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive requests, check everything, then advance the expected history.
  task automatic cyc(input logic [N-1:0] rv, input int eg);
    req_valid = rv;
    #1;
    check("req_ready",  32'(req_ready),  eg < 0 ? 32'd0 : (32'd1 << eg));
    check("req_ready3", 32'(req_ready3), eg < 0 ? 32'd0 : (32'd1 << eg));
    if (hist[1] >= 0) begin
      last_a = A_TAB[hist[1]];
      last_b = B_TAB[hist[1]];
      last_c = C_TAB[hist[1]];
    end
    check("op_valid", 32'(op_valid), 32'(hist[1] >= 0));
    check("op_a", op_a, last_a);
    check("op_b", op_b, last_b);
    check("op_c", op_c, last_c);
    if (hist[3] >= 0) begin
      last_id = hist[3];
      last_d  = D_TAB[hist[3]];
    end
    check("rsp_valid", 32'(rsp_valid), hist[3] < 0 ? 32'd0 : (32'd1 << hist[3]));
    check("rsp_id",    32'(rsp_id),    32'(last_id));
    check("rsp_d",     rsp_d,          last_d);
    if (hist[5] >= 0) begin
      last_id3 = hist[5];
      last_d3  = D_TAB[hist[5]];
    end
    check("rsp_valid3", 32'(rsp_valid3), hist[5] < 0 ? 32'd0 : (32'd1 << hist[5]));
    check("rsp_id3",    32'(rsp_id3),    32'(last_id3));
    check("rsp_d3",     rsp_d3,          last_d3);
    check("busy",  32'(busy),  32'(hist[1] >= 0 || hist[2] >= 0 || hist[3] >= 0));
    check("busy3", 32'(busy3), 32'(hist[1] >= 0 || hist[2] >= 0 || hist[3] >= 0 ||
                                   hist[4] >= 0 || hist[5] >= 0));
    @(posedge clk);
    for (int i = 5; i > 1; i--) hist[i] = hist[i-1];
    hist[1] = eg;
    #1;
  endtask

  task automatic rst_cycle();
    reset     = 1'b1;
    req_valid = '1;
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_req_ready3", 32'(req_ready3), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_busy3",      32'(busy3),      32'd0);
    check("rst_op_valid",   32'(op_valid),   32'd0);
    check("rst_op_a",       op_a,            32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_valid3", 32'(rsp_valid3), 32'd0);
    check("rst_rsp_id",     32'(rsp_id),     32'd0);
    check("rst_rsp_d",      rsp_d,           32'd0);
    for (int i = 1; i <= 5; i++) hist[i] = -1;
    last_id = 0; last_id3 = 0;
    last_a = '0; last_b = '0; last_c = '0; last_d = '0; last_d3 = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = A_TAB[i];
      req_b[32*i +: 32] = B_TAB[i];
      req_c[32*i +: 32] = C_TAB[i];
    end
    #1;
    rst_cycle();

    // Single op from requester 0: 1.0 + 2.0 - 0.5 = 2.5, then requester 3 to bring the pointer back to 0.
    cyc(4'b0001, 0);
    repeat (4) cyc(4'b0000, -1);
    cyc(4'b1000, 3);

    // Fairness with all four requesting; covers 3-0-5=-2.0 and 1+1-2=0.0 results.
    for (int k = 0; k < 8; k++) cyc(4'b1111, k % 4);

    // Wrap and skip from pointer 3.
    cyc(4'b0100, 2);
    cyc(4'b0101, 0);
    cyc(4'b0101, 2);
    cyc(4'b1001, 3);
    cyc(4'b1001, 0);
    repeat (5) cyc(4'b0000, -1);

    // Reset with two ops in flight: nothing may come back, pointer restarts at 0.
    cyc(4'b0001, 0);
    cyc(4'b0010, 1);
    rst_cycle();
    repeat (5) cyc(4'b0000, -1);
    cyc(4'b1010, 1);

    // Alternating requesters, checked on both latencies.
    cyc(4'b0010, 1);
    cyc(4'b1000, 3);
    cyc(4'b0010, 1);
    cyc(4'b1000, 3);
    repeat (6) cyc(4'b0000, -1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
